// File: rtl/audio_mix_dsm.sv
// rtl/audio_mix_dsm.sv - N-channel gain mixer with saturation and first-order delta-sigma output
module audio_mix_dsm #(
  parameter int NUM_CH = 5,
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     sample_stb,
  input  logic [NUM_CH*IN_W-1:0]   ch_in,
  input  logic [NUM_CH-1:0]        ch_signed,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  input  logic                     mute,
  input  logic                     mode,
  output logic [OUT_W-1:0]         pcm_out,
  output logic                     pcm_valid,
  output logic                     busy,
  output logic                     clip,
  output logic                     overrun,
  output logic                     dsm_out
);

  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam int ACC_W  = IN_W + GAIN_W + $clog2(NUM_CH) + 1;
  // idx runs one step past the last channel to drain the product register
  localparam int IDX_W  = $clog2(NUM_CH + 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_t;

  state_t                     state;
  logic [NUM_CH*IN_W-1:0]     in_q;
  logic [NUM_CH-1:0]          sgn_q;
  logic [NUM_CH*GAIN_W-1:0]   gain_q;
  logic [IDX_W-1:0]           idx;
  logic signed [PROD_W-1:0]   prod_q;
  logic signed [ACC_W-1:0]    acc;
  logic [OUT_W-1:0]           dsm_acc;

  logic [IN_W-1:0]            raw_sel;
  logic [GAIN_W-1:0]          gain_sel;
  logic                       sgn_sel;
  logic signed [IN_W-1:0]     smp_sel;
  logic signed [PROD_W-1:0]   prod_sel;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [ACC_W-1:0]    sat_val;
  logic                       sat_hit;
  logic [OUT_W-1:0]           dsm_u;
  logic [OUT_W:0]             dsm_sum;

  // Pick the snapshotted channel at idx and form its signed, gain-weighted product
  always_comb begin
    raw_sel  = '0;
    gain_sel = '0;
    sgn_sel  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == IDX_W'(k)) begin
        raw_sel  = in_q[k*IN_W +: IN_W];
        gain_sel = gain_q[k*GAIN_W +: GAIN_W];
        sgn_sel  = sgn_q[k];
      end
    end
    smp_sel  = sgn_sel ? raw_sel : {~raw_sel[IN_W-1], raw_sel[IN_W-2:0]};
    prod_sel = $signed({{(GAIN_W+1){smp_sel[IN_W-1]}}, smp_sel})
             * $signed({{(IN_W+1){1'b0}}, gain_sel});
  end

  assign prod_ext = ACC_W'(prod_q);

  // Remove the unity-gain factor of 8 and clamp to the signed PCM range
  always_comb begin
    shifted = acc >>> 3;
    sat_hit = 1'b0;
    sat_val = shifted;
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX;
      sat_hit = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN;
      sat_hit = 1'b1;
    end
  end

  // Mix sequencer: snapshot, accumulate one channel per clock, then scale and publish
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_q      <= '0;
      sgn_q     <= '0;
      gain_q    <= '0;
      idx       <= '0;
      prod_q    <= '0;
      acc       <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      busy      <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      pcm_valid <= 1'b0;
      if (sample_stb && busy) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (sample_stb) begin
            in_q   <= ch_in;
            sgn_q  <= ch_signed;
            gain_q <= ch_gain;
            acc    <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          // product of channel idx is registered here and summed on the next step
          if (idx != IDX_W'(NUM_CH)) begin
            prod_q <= prod_sel;
          end
          if (idx != '0) begin
            acc <= acc + prod_ext;
          end
          if (idx == IDX_W'(NUM_CH)) begin
            state <= SCALE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        SCALE: begin
          pcm_out   <= mute ? '0 : sat_val[OUT_W-1:0];
          clip      <= !mute && sat_hit;
          pcm_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dsm_u   = {~pcm_out[OUT_W-1], pcm_out[OUT_W-2:0]};
  assign dsm_sum = {1'b0, dsm_acc} + {1'b0, dsm_u};

  // First-order delta-sigma: the accumulator carry is the output bit
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dsm_acc <= '0;
      dsm_out <= 1'b0;
    end else if (mode) begin
      dsm_acc <= dsm_sum[OUT_W-1:0];
      dsm_out <= dsm_sum[OUT_W];
    end else begin
      dsm_acc <= '0;
      dsm_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_mix_dsm.sv
// tb/tb_audio_mix_dsm.sv - self-checking bench for audio_mix_dsm with a two-channel instance
module tb_audio_mix_dsm;

  localparam int N = 2;

  logic        clk_sys;
  logic        reset_n;
  logic        sample_stb;
  logic [31:0] ch_in;
  logic [1:0]  ch_signed;
  logic [7:0]  ch_gain;
  logic        mute;
  logic        mode;
  logic [15:0] pcm_out;
  logic        pcm_valid;
  logic        busy;
  logic        clip;
  logic        overrun;
  logic        dsm_out;

  int n_assert = 0;
  int n_fail   = 0;

  audio_mix_dsm #(.NUM_CH(N), .IN_W(16), .OUT_W(16), .GAIN_W(4)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .sample_stb(sample_stb),
    .ch_in(ch_in), .ch_signed(ch_signed), .ch_gain(ch_gain),
    .mute(mute), .mode(mode), .pcm_out(pcm_out), .pcm_valid(pcm_valid),
    .busy(busy), .clip(clip), .overrun(overrun), .dsm_out(dsm_out)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference mix: offset-binary means value minus half scale, gain/8, floor, clamp
  function automatic logic [16:0] ref_mix(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] sg, input logic [3:0] ga,
                                          input logic [3:0] gb, input logic mu);
    longint s0, s1, sum, v;
    logic clp;
    s0  = sg[0] ? longint'($signed(a)) : longint'(a) - 32768;
    s1  = sg[1] ? longint'($signed(b)) : longint'(b) - 32768;
    sum = s0 * longint'(ga) + s1 * longint'(gb);
    v   = sum >>> 3;
    clp = 1'b0;
    if (v > 32767) begin v = 32767; clp = 1'b1; end
    else if (v < -32768) begin v = -32768; clp = 1'b1; end
    if (mu) begin v = 0; clp = 1'b0; end
    return {clp, 16'(v)};
  endfunction

  task automatic do_mix(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] sg, input logic [3:0] ga, input logic [3:0] gb,
                        input logic mu);
    logic [16:0] e;
    int lat;
    logic bsy_ok;
    e = ref_mix(a, b, sg, ga, gb, mu);
    ch_in = {b, a}; ch_signed = sg; ch_gain = {gb, ga}; mute = mu;
    sample_stb = 1'b1;
    tick();
    sample_stb = 1'b0;
    ch_in = $urandom; ch_signed = 2'($urandom); ch_gain = 8'($urandom);
    lat = 0; bsy_ok = 1'b1;
    while (!pcm_valid && lat < 20) begin
      if (busy !== 1'b1) bsy_ok = 1'b0;
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, N + 2);
    check({tag, "_busy"}, bsy_ok, 1);
    check({tag, "_pcm"}, pcm_out, e[15:0]);
    check({tag, "_clip"}, clip, e[16]);
    tick();
    check({tag, "_pulse"}, pcm_valid, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold"}, pcm_out, e[15:0]);
  endtask

  task automatic run_dsm(input int ncyc, input logic [15:0] pcm, output int ones, output int mism);
    int macc, u, bitv;
    u = int'({~pcm[15], pcm[14:0]});
    macc = 0; ones = 0; mism = 0;
    mode = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      tick();
      macc = macc + u;
      bitv = macc >> 16;
      macc = macc & 32'hFFFF;
      if (dsm_out !== bitv[0]) mism++;
      if (dsm_out === 1'b1) ones++;
    end
    mode = 1'b0;
  endtask

  initial begin
    int vc, ones, mism;
    logic [15:0] ra, rb;
    logic [15:0] got;
    reset_n = 1'b0; sample_stb = 1'b0; ch_in = '0; ch_signed = '0;
    ch_gain = '0; mute = 1'b0; mode = 1'b0;
    repeat (3) tick();
    check("rst_pcm", pcm_out, 0);
    check("rst_valid", pcm_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_clip", clip, 0);
    check("rst_overrun", overrun, 0);
    check("rst_dsm", dsm_out, 0);
    reset_n = 1'b1;
    tick();

    do_mix("unity", 16'h1000, 16'h2000, 2'b11, 4'd8, 4'd8, 1'b0);
    check("unity_exact", pcm_out, 16'h3000);
    do_mix("sat_pos", 16'h7000, 16'h7000, 2'b11, 4'd15, 4'd15, 1'b0);
    check("sat_pos_exact", {clip, pcm_out}, 17'h17FFF);
    do_mix("sat_neg", 16'h9000, 16'h9000, 2'b11, 4'd15, 4'd15, 1'b0);
    check("sat_neg_exact", {clip, pcm_out}, 17'h18000);
    do_mix("uns_mid", 16'h8000, 16'h1234, 2'b00, 4'd8, 4'd0, 1'b0);
    check("uns_mid_exact", pcm_out, 16'h0000);
    do_mix("uns_c000", 16'hC000, 16'h5555, 2'b00, 4'd4, 4'd0, 1'b0);
    check("uns_c000_exact", pcm_out, 16'h2000);
    do_mix("mute", 16'h7000, 16'h7000, 2'b11, 4'd15, 4'd15, 1'b1);
    check("mute_exact", {clip, pcm_out}, 17'h00000);
    check("no_overrun", overrun, 0);
    check("dsm_off", dsm_out, 0);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      do_mix("rand", ra, rb, 2'($urandom), 4'($urandom), 4'($urandom),
             ($urandom_range(0, 7) == 0));
    end

    // Second strobe two cycles into a mix is dropped and flagged
    mute = 1'b0;
    ch_in = {16'h0800, 16'h1000}; ch_signed = 2'b11; ch_gain = 8'h88;
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    tick();
    ch_in = {16'h4000, 16'h4000}; ch_gain = 8'hFF;
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    vc = 0; got = '0;
    for (int i = 0; i < 15; i++) begin
      if (pcm_valid === 1'b1) begin vc++; got = pcm_out; end
      tick();
    end
    check("ovr_valid_count", vc, 1);
    check("ovr_result", got, 16'h1800);
    check("ovr_flag", overrun, 1);
    do_mix("ovr_sticky", 16'h0100, 16'h0100, 2'b11, 4'd8, 4'd8, 1'b0);
    check("ovr_still_set", overrun, 1);

    // Asynchronous reset in the middle of accumulation
    ch_in = {16'h2000, 16'h2000}; ch_gain = 8'h88; ch_signed = 2'b11;
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("amid_pcm", pcm_out, 0);
    check("amid_busy", busy, 0);
    check("amid_overrun", overrun, 0);
    check("amid_valid", pcm_valid, 0);
    tick(); tick();
    reset_n = 1'b1;
    vc = 0;
    for (int i = 0; i < N + 6; i++) begin
      tick();
      if (pcm_valid === 1'b1) vc++;
    end
    check("amid_no_valid", vc, 0);
    do_mix("post_rst", 16'h0400, 16'hFC00, 2'b11, 4'd8, 4'd4, 1'b0);
    check("post_rst_ovr", overrun, 0);

    // Strobe coinciding with the scale cycle counts as an overrun and is ignored
    ch_in = {16'h0200, 16'h0200}; ch_gain = 8'h88; ch_signed = 2'b11;
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    repeat (N + 1) tick();
    sample_stb = 1'b1; tick(); sample_stb = 1'b0;
    check("scale_stb_valid", pcm_valid, 1);
    check("scale_stb_pcm", pcm_out, 16'h0400);
    check("scale_stb_ovr", overrun, 1);
    tick();
    check("scale_stb_busy", busy, 0);
    vc = 0;
    for (int i = 0; i < N + 4; i++) begin
      if (pcm_valid === 1'b1) vc++;
      tick();
    end
    check("scale_stb_nomix", vc, 0);

    // Delta-sigma bitstreams at mid scale, negative full scale, positive full scale
    do_mix("dsm_zero", 16'h1111, 16'h2222, 2'b11, 4'd0, 4'd0, 1'b0);
    run_dsm(256, 16'h0000, ones, mism);
    check("dsm_zero_ones", ones, 128);
    check("dsm_zero_seq", mism, 0);
    vc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (dsm_out !== 1'b0) vc++;
    end
    check("dsm_mode0", vc, 0);
    do_mix("dsm_min", 16'h9000, 16'h9000, 2'b11, 4'd15, 4'd15, 1'b0);
    run_dsm(256, 16'h8000, ones, mism);
    check("dsm_min_ones", ones, 0);
    check("dsm_min_seq", mism, 0);
    do_mix("dsm_max", 16'h7000, 16'h7000, 2'b11, 4'd15, 4'd15, 1'b0);
    run_dsm(65536, 16'h7FFF, ones, mism);
    check("dsm_max_ones", ones, 65535);
    check("dsm_max_seq", mism, 0);
    tick();
    check("dsm_off_end", dsm_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_mix_dsm.md
Name: audio_mix_dsm

Overview:
- Parametrised N-channel audio mixer for arcade cores. Replaces the fixed five-source, ad-hoc PWM accumulator in the top level.
- Snapshots all channel inputs on a sample strobe and converts unsigned sources to signed.
- Applies a per-channel 4-bit gain, then accumulates the channels sequentially, one per clock.
- Saturates the sum to a signed PCM word and, selectably, drives a first-order delta-sigma 1-bit output for PWM-style pins.

Parameters:
- NUM_CH, 5, number of input channels (1..16).
- IN_W, 16, width of each channel sample; narrower sources are left-justified by the instantiator.
- OUT_W, 16, width of the signed PCM output and of the delta-sigma accumulator.
- GAIN_W, 4, per-channel gain width; gain value 8 is unity (result shifted right by 3).

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sample_stb  in  1  one-cycle request to mix a new sample.
- ch_in  in  NUM_CH*IN_W  channel samples; channel k occupies bits [k*IN_W +: IN_W].
- ch_signed  in  NUM_CH  per channel: 1 = two's complement, 0 = offset binary.
- ch_gain  in  NUM_CH*GAIN_W  per-channel gain, unsigned, 0..15.
- mute  in  1  forces the PCM result to 0.
- mode  in  1  0 = PCM only, dsm_out held at 0; 1 = delta-sigma active.
- pcm_out  out  OUT_W  signed mixed sample.
- pcm_valid  out  1  one-cycle pulse when pcm_out updates.
- busy  out  1  high while a mix is in progress.
- clip  out  1  high when the last result saturated; updated with pcm_valid.
- overrun  out  1  sticky; set when sample_stb arrives while busy.
- dsm_out  out  1  delta-sigma bitstream.

Behaviour:
- Reset (async, reset_n low): every output is 0, the accumulator and channel index are 0, the DSM accumulator is 0, state is IDLE. Reset asserted mid-mix aborts the mix; no pcm_valid is produced.
- States are IDLE -> ACCUM -> SCALE -> IDLE.
- IDLE:
  - On sample_stb, register ch_in, ch_signed and ch_gain.
  - Clear the accumulator, set idx = 0, set busy = 1, go to ACCUM.
- ACCUM (NUM_CH cycles, one channel per cycle, index idx):
  - Signed conversion: if ch_signed[idx] = 0, invert the sample MSB; otherwise take the sample as-is.
  - Product = signed sample * zero-extended gain.
  - Accumulator width is IN_W + GAIN_W + ceil(log2(NUM_CH)) + 1, so the accumulator never wraps.
  - After idx = NUM_CH-1, go to SCALE.
- SCALE (1 cycle):
  - Arithmetic shift right by 3.
  - Saturate to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1]; clip = 1 if saturation occurred, else 0.
  - If mute = 1, pcm_out = 0 and clip = 0.
  - Register pcm_out, pulse pcm_valid for one cycle, set busy = 0, return to IDLE.
- Latency: pcm_valid is asserted exactly NUM_CH+2 clocks after the clock edge that samples sample_stb.
- pcm_out holds its value between updates.
- sample_stb while busy: the strobe is ignored, the current mix completes unaffected, and overrun is set. overrun clears only on reset.
- A sample_stb in the same cycle as the SCALE completion is also an overrun, because busy is still 1 in that cycle.
- Gain 0 contributes 0. The inputs are snapshotted, so changing ch_in during ACCUM has no effect on the current mix.
- Delta-sigma, evaluated every clock when mode = 1:
  - u = pcm_out with its MSB inverted (offset binary).
  - {carry, acc} <= acc + u, with acc OUT_W bits wide.
  - dsm_out <= carry.
- When mode = 0: acc is held at 0 and dsm_out = 0. Switching mode 0 -> 1 starts from acc = 0.

Test Plan:
- Unity mix: NUM_CH=2, ch0 = 0x1000 signed, ch1 = 0x2000 signed, gains 8/8, strobe -> pcm_out = 0x3000, clip = 0, pcm_valid exactly 4 clocks after the strobe, busy high for those cycles.
- Saturation: ch0 = ch1 = 0x7000 signed, gain 15 -> pcm_out = 0x7FFF, clip = 1. With ch0 = ch1 = 0x9000, gain 15 -> pcm_out = 0x8000, clip = 1.
- Unsigned conversion and gain: ch0 = 0x8000 unsigned, gain 8 -> contributes 0. ch0 = 0xC000 unsigned, gain 4 -> pcm_out = 0x2000. With mute = 1 -> pcm_out = 0, clip = 0.
- Overrun: a second strobe 2 cycles after the first -> exactly one pcm_valid with the first snapshot's result, overrun = 1 until reset.
- Delta-sigma: mode = 1, pcm_out = 0x0000 -> exactly 128 ones in 256 clocks, alternating. pcm_out = 0x8000 -> all zeros. pcm_out = 0x7FFF -> 65535 ones per 65536 clocks. mode = 0 -> dsm_out constant 0.
- Reset mid-operation: assert reset_n = 0 during ACCUM -> all outputs 0 immediately (async), no pcm_valid. Release reset, then strobe -> normal result after NUM_CH+2 clocks.
